trace_capture_ctrl: RTL and testbench
=====================================

Name: trace_capture_ctrl

Overview:
Parametrised on-chip sensor trace acquisition controller. It replaces the fixed single-sensor, fixed-depth sample FSM with a configurable one. After a trigger (encryption start) it captures a configurable window of decoded sensor samples from NUM_CH channels and writes them to trace memory. The window is set by post-trigger offset, length, decimation and channel mode. It holds a done/ack handshake with the transmit sequencer.

Parameters:
NUM_CH, 4, number of sensor channels packed on sample_in
SAMPLE_W, 8, width of one decoded sensor sample
DEPTH, 1024, trace memory capacity in words
ADDR_W, 16, trace memory address width
OFFSET_W, 16, width of post-trigger delay count
DECIM_W, 4, width of decimation setting

Ports:
clk  in  1  capture clock (sensor sample clock)
rst  in  1  reset, synchronous, active-high
cfg_wr  in  1  latch cfg_* into internal registers (accepted only in IDLE)
cfg_offset  in  OFFSET_W  cycles to wait after trigger before capture
cfg_len  in  ADDR_W  samples per enabled channel; 0 means DEPTH
cfg_decim  in  DECIM_W  keep one tick in (cfg_decim+1)
cfg_mode  in  1  0 = single channel cfg_ch; 1 = round-robin all channels
cfg_ch  in  $clog2(NUM_CH)  channel used in mode 0
arm  in  1  one-cycle pulse: IDLE -> ARMED
trigger  in  1  capture start event (level; rising edge not required)
sample_in  in  NUM_CH*SAMPLE_W  channel k occupies bits [k*SAMPLE_W +: SAMPLE_W]
mem_w_en  out  1  trace memory write strobe
mem_w_addr  out  ADDR_W  trace memory write address
mem_w_data  out  SAMPLE_W  trace memory write data
busy  out  1  high in ARMED, DELAY, CAPTURE
done  out  1  capture complete; held until done_ack
done_ack  in  1  transmit sequencer releases the buffer
cfg_clamped  out  1  sticky: last latched config exceeded DEPTH and was clamped
retrig  out  1  sticky: trigger seen during DELAY/CAPTURE; cleared on arm

Behaviour:
- Reset: state IDLE. All outputs 0. Config registers: offset 0, len 0, decim 0, mode 0, ch 0.
- total_words = (len==0 ? DEPTH : len) * (mode ? NUM_CH : 1), computed at cfg_wr. If the result exceeds DEPTH it is clamped to DEPTH and cfg_clamped is set; cfg_clamped is cleared by a non-clamping cfg_wr.
- sample_q registers sample_in every cycle.
- IDLE: cfg_wr accepted. arm -> ARMED, clears retrig. trigger is ignored. If arm and trigger arrive in the same cycle, only arm is acted on.
- ARMED: cfg_wr and arm are ignored. trigger -> DELAY if offset != 0, else -> CAPTURE. The delay counter loads offset-1.
- DELAY: counter decrements each cycle; at 0 -> CAPTURE. DELAY therefore lasts exactly offset cycles.
- CAPTURE entry: decim counter = 0, channel pointer = 0 (mode 1) or cfg_ch (mode 0), mem_w_addr = 0.
- Each CAPTURE cycle with decim counter == 0 is a kept tick. On a kept tick:
  - the next cycle asserts mem_w_en with mem_w_data = sample_q[ptr];
  - mem_w_addr is incremented after each write;
  - in mode 1, ptr advances modulo NUM_CH.
- Decim counter wraps at cfg_decim.
- Latency: trigger sampled at cycle T with offset 0 gives the first mem_w_en at T+2, carrying the sample_in value present at T+1. With offset N, the first write is at T+2+N.
- Write count: after the write at address total_words-1 -> DONE. mem_w_en is 0 from then on. Exactly total_words writes occur; addresses are 0..total_words-1 with no wrap.
- DONE: done=1, mem_w_addr is held. done_ack -> IDLE, with done=0 the next cycle. A done_ack outside DONE is ignored.
- trigger in DELAY or CAPTURE sets retrig and does not restart capture.
- rst mid-operation: IDLE on the next edge; mem_w_en=0; a partial trace is discarded with no done.
- busy and done are never high together.

Test Plan:
- Single channel: cfg len=8, decim=0, mode=0, ch=2, offset=0; arm; trigger at T -> 8 writes at T+2..T+9, addr 0..7, data = channel 2 of sample_in at T+1..T+8; done at T+10; held until done_ack; then IDLE.
- Offset and decimation: offset=5, decim=2, len=4 -> writes at T+7, T+10, T+13, T+16; addr 0..3.
- Round-robin with NUM_CH=4: mode=1, len=3 -> 12 writes; data channel order 0,1,2,3 repeating; last addr 11.
- Clamp: len=300, mode=1 (1200 words) -> cfg_clamped=1; exactly 1024 writes; last addr 1023; done.
- Events: trigger in IDLE -> no writes; arm+trigger in the same cycle -> ARMED only; trigger during CAPTURE -> retrig=1 and write count unchanged; next arm clears retrig.
- Reset at write 3 of 8 -> mem_w_en=0 and busy=0 the next cycle, no done; a following arm/trigger restarts at addr 0.

Source files
------------

// File: rtl/trace_capture_ctrl.sv
// Configurable multi-channel trace acquisition controller: waits a post-trigger offset,
// then writes a decimated window of sensor samples to trace memory and hands off via done/ack.
module trace_capture_ctrl #(
    parameter int NUM_CH   = 4,
    parameter int SAMPLE_W = 8,
    parameter int DEPTH    = 1024,
    parameter int ADDR_W   = 16,
    parameter int OFFSET_W = 16,
    parameter int DECIM_W  = 4,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_wr,
    input  logic [OFFSET_W-1:0]        cfg_offset,
    input  logic [ADDR_W-1:0]          cfg_len,
    input  logic [DECIM_W-1:0]         cfg_decim,
    input  logic                       cfg_mode,
    input  logic [CH_W-1:0]            cfg_ch,
    input  logic                       arm,
    input  logic                       trigger,
    input  logic [NUM_CH*SAMPLE_W-1:0] sample_in,
    output logic                       mem_w_en,
    output logic [ADDR_W-1:0]          mem_w_addr,
    output logic [SAMPLE_W-1:0]        mem_w_data,
    output logic                       busy,
    output logic                       done,
    input  logic                       done_ack,
    output logic                       cfg_clamped,
    output logic                       retrig
);

    localparam int PW = ADDR_W + CH_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_DELAY   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [OFFSET_W-1:0]   offset_q, offset_d;
    logic [DECIM_W-1:0]    decim_q, decim_d;
    logic                  mode_q, mode_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic [PW-1:0]         tot_q, tot_d;
    logic                  cfg_clamped_q, cfg_clamped_d;
    logic                  retrig_q, retrig_d;
    logic [OFFSET_W-1:0]   dly_q, dly_d;
    logic [DECIM_W-1:0]    dec_q, dec_d;
    logic [CH_W-1:0]       ptr_q, ptr_d;
    logic [PW-1:0]         issued_q, issued_d;
    logic                  mem_w_en_q, mem_w_en_d;
    logic [ADDR_W-1:0]     mem_w_addr_q, mem_w_addr_d;
    logic [SAMPLE_W-1:0]   mem_w_data_q, mem_w_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [PW-1:0]         len_eff_s;
    logic [PW-1:0]         prod_s;
    logic                  kept_s;
    logic                  last_wr_s;

    // Next-state, counter and output computation for the whole controller.
    always_comb begin
        state_d       = state_q;
        offset_d      = offset_q;
        decim_d       = decim_q;
        mode_d        = mode_q;
        ch_d          = ch_q;
        tot_d         = tot_q;
        cfg_clamped_d = cfg_clamped_q;
        retrig_d      = retrig_q;
        dly_d         = dly_q;
        dec_d         = dec_q;
        ptr_d         = ptr_q;
        issued_d      = issued_q;
        mem_w_en_d    = 1'b0;
        mem_w_addr_d  = mem_w_addr_q;
        mem_w_data_d  = mem_w_data_q;

        len_eff_s = (cfg_len == {ADDR_W{1'b0}}) ? PW'(DEPTH) : PW'(cfg_len);
        prod_s    = cfg_mode ? (len_eff_s * PW'(NUM_CH)) : len_eff_s;
        // A kept tick is only issued while writes remain, so the final write cycle issues nothing.
        kept_s    = (state_q == ST_CAPTURE) && (dec_q == {DECIM_W{1'b0}}) && (issued_q != tot_q);
        last_wr_s = mem_w_en_q && (PW'(mem_w_addr_q) == (tot_q - PW'(1)));

        case (state_q)
            ST_IDLE: begin
                if (cfg_wr) begin
                    offset_d = cfg_offset;
                    decim_d  = cfg_decim;
                    mode_d   = cfg_mode;
                    ch_d     = cfg_ch;
                    if (prod_s > PW'(DEPTH)) begin
                        tot_d         = PW'(DEPTH);
                        cfg_clamped_d = 1'b1;
                    end else begin
                        tot_d         = prod_s;
                        cfg_clamped_d = 1'b0;
                    end
                end else begin
                    tot_d = tot_q;
                end
                if (arm) begin
                    state_d  = ST_ARMED;
                    retrig_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (trigger) begin
                    if (offset_q != {OFFSET_W{1'b0}}) begin
                        state_d = ST_DELAY;
                        dly_d   = offset_q - OFFSET_W'(1);
                    end else begin
                        state_d      = ST_CAPTURE;
                        dec_d        = {DECIM_W{1'b0}};
                        ptr_d        = mode_q ? {CH_W{1'b0}} : ch_q;
                        issued_d     = {PW{1'b0}};
                        mem_w_addr_d = {ADDR_W{1'b0}};
                    end
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_DELAY: begin
                if (trigger) begin
                    retrig_d = 1'b1;
                end else begin
                    retrig_d = retrig_q;
                end
                if (dly_q == {OFFSET_W{1'b0}}) begin
                    state_d      = ST_CAPTURE;
                    dec_d        = {DECIM_W{1'b0}};
                    ptr_d        = mode_q ? {CH_W{1'b0}} : ch_q;
                    issued_d     = {PW{1'b0}};
                    mem_w_addr_d = {ADDR_W{1'b0}};
                end else begin
                    dly_d = dly_q - OFFSET_W'(1);
                end
            end
            ST_CAPTURE: begin
                if (trigger) begin
                    retrig_d = 1'b1;
                end else begin
                    retrig_d = retrig_q;
                end
                dec_d = (dec_q == decim_q) ? {DECIM_W{1'b0}} : (dec_q + DECIM_W'(1));
                if (kept_s) begin
                    mem_w_en_d   = 1'b1;
                    mem_w_data_d = sample_in[ptr_q*SAMPLE_W +: SAMPLE_W];
                    issued_d     = issued_q + PW'(1);
                    if (mode_q) begin
                        ptr_d = (ptr_q == CH_W'(NUM_CH - 1)) ? {CH_W{1'b0}} : (ptr_q + CH_W'(1));
                    end else begin
                        ptr_d = ptr_q;
                    end
                end else begin
                    mem_w_en_d = 1'b0;
                end
                if (last_wr_s) begin
                    state_d = ST_DONE;
                end else if (mem_w_en_q) begin
                    mem_w_addr_d = mem_w_addr_q + ADDR_W'(1);
                end else begin
                    mem_w_addr_d = mem_w_addr_q;
                end
            end
            ST_DONE: begin
                if (done_ack) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_ARMED) || (state_d == ST_DELAY) || (state_d == ST_CAPTURE);
        done_d = (state_d == ST_DONE);
    end

    // State, configuration and registered outputs; reset discards any partial capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            offset_q      <= {OFFSET_W{1'b0}};
            decim_q       <= {DECIM_W{1'b0}};
            mode_q        <= 1'b0;
            ch_q          <= {CH_W{1'b0}};
            tot_q         <= PW'(DEPTH);
            cfg_clamped_q <= 1'b0;
            retrig_q      <= 1'b0;
            dly_q         <= {OFFSET_W{1'b0}};
            dec_q         <= {DECIM_W{1'b0}};
            ptr_q         <= {CH_W{1'b0}};
            issued_q      <= {PW{1'b0}};
            mem_w_en_q    <= 1'b0;
            mem_w_addr_q  <= {ADDR_W{1'b0}};
            mem_w_data_q  <= {SAMPLE_W{1'b0}};
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            offset_q      <= offset_d;
            decim_q       <= decim_d;
            mode_q        <= mode_d;
            ch_q          <= ch_d;
            tot_q         <= tot_d;
            cfg_clamped_q <= cfg_clamped_d;
            retrig_q      <= retrig_d;
            dly_q         <= dly_d;
            dec_q         <= dec_d;
            ptr_q         <= ptr_d;
            issued_q      <= issued_d;
            mem_w_en_q    <= mem_w_en_d;
            mem_w_addr_q  <= mem_w_addr_d;
            mem_w_data_q  <= mem_w_data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign mem_w_en    = mem_w_en_q;
    assign mem_w_addr  = mem_w_addr_q;
    assign mem_w_data  = mem_w_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cfg_clamped = cfg_clamped_q;
    assign retrig      = retrig_q;

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Directed bench for trace_capture_ctrl: each channel byte of sample_in at bench cycle n is
// (4*n + k) mod 256, so expected write data follows directly from the write's cycle number.
module tb_trace_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst, cfg_wr, cfg_mode, arm, trigger, done_ack;
    logic [15:0] cfg_offset, cfg_len;
    logic [3:0]  cfg_decim;
    logic [1:0]  cfg_ch;
    logic [31:0] sample_in;
    logic        mem_w_en, busy, done, cfg_clamped, retrig;
    logic [15:0] mem_w_addr;
    logic [7:0]  mem_w_data;

    int ncyc = 0;
    int wcount = 0;
    int checks = 0;
    int passes = 0;
    int fails = 0;
    int t;
    int wr_cyc [2048];
    int wr_addr[2048];
    int wr_data[2048];

    trace_capture_ctrl dut (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_offset(cfg_offset), .cfg_len(cfg_len),
        .cfg_decim(cfg_decim), .cfg_mode(cfg_mode), .cfg_ch(cfg_ch), .arm(arm),
        .trigger(trigger), .sample_in(sample_in), .mem_w_en(mem_w_en),
        .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data), .busy(busy), .done(done),
        .done_ack(done_ack), .cfg_clamped(cfg_clamped), .retrig(retrig)
    );

    always #5 clk = ~clk;

    task automatic tick();
        for (int k = 0; k < 4; k++) sample_in[k*8 +: 8] = 8'((ncyc * 4 + k) & 255);
        @(posedge clk);
        #1;
        ncyc++;
        if (mem_w_en) begin
            if (wcount < 2048) begin
                wr_cyc[wcount]  = ncyc;
                wr_addr[wcount] = int'(mem_w_addr);
                wr_data[wcount] = int'(mem_w_data);
            end
            wcount++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic configure(input int off, input int len, input int dec, input int mode, input int ch);
        cfg_offset = 16'(off); cfg_len = 16'(len); cfg_decim = 4'(dec);
        cfg_mode = 1'(mode); cfg_ch = 2'(ch);
        cfg_wr = 1'b1; tick(); cfg_wr = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit && !done; i++) tick();
    endtask

    initial begin
        rst = 1'b1; cfg_wr = 1'b0; cfg_mode = 1'b0; arm = 1'b0; trigger = 1'b0; done_ack = 1'b0;
        cfg_offset = 16'd0; cfg_len = 16'd0; cfg_decim = 4'd0; cfg_ch = 2'd0; sample_in = 32'd0;
        tick(); tick();
        check("rst_wen", mem_w_en, 1'b0);
        check("rst_addr", mem_w_addr, 16'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_clamp", cfg_clamped, 1'b0);
        check("rst_retrig", retrig, 1'b0);
        rst = 1'b0; tick();

        // Single channel 2, len 8, no offset, no decimation.
        configure(0, 8, 0, 0, 2);
        arm = 1'b1; tick(); arm = 1'b0;
        check("t1_armed_busy", busy, 1'b1);
        wcount = 0; t = ncyc;
        trigger = 1'b1; tick(); trigger = 1'b0;
        repeat (9) tick();
        check("t1_count", wcount, 8);
        check("t1_first_cyc", wr_cyc[0], t + 2);
        check("t1_last_cyc", wr_cyc[7], t + 9);
        for (int i = 0; i < 8; i++) begin
            check("t1_addr", wr_addr[i], i);
            check("t1_data", wr_data[i], ((t + 1 + i) * 4 + 2) & 255);
        end
        check("t1_done", done, 1'b1);
        check("t1_busy_low", busy, 1'b0);
        check("t1_addr_hold", mem_w_addr, 16'd7);
        repeat (3) tick();
        check("t1_done_held", done, 1'b1);
        check("t1_no_more_wr", wcount, 8);
        done_ack = 1'b1; tick(); done_ack = 1'b0;
        check("t1_ack_done", done, 1'b0);
        check("t1_ack_busy", busy, 1'b0);

        // Offset 5, decimation 2, len 4 on channel 1.
        configure(5, 4, 2, 0, 1);
        arm = 1'b1; tick(); arm = 1'b0;
        wcount = 0; t = ncyc;
        trigger = 1'b1; tick(); trigger = 1'b0;
        repeat (16) tick();
        check("t2_count", wcount, 4);
        for (int i = 0; i < 4; i++) begin
            check("t2_cyc", wr_cyc[i], t + 7 + 3 * i);
            check("t2_addr", wr_addr[i], i);
            check("t2_data", wr_data[i], ((t + 6 + 3 * i) * 4 + 1) & 255);
        end
        check("t2_done", done, 1'b1);
        done_ack = 1'b1; tick(); done_ack = 1'b0;

        // Round-robin over all four channels, len 3.
        configure(0, 3, 0, 1, 0);
        check("t3_no_clamp", cfg_clamped, 1'b0);
        arm = 1'b1; tick(); arm = 1'b0;
        wcount = 0; t = ncyc;
        trigger = 1'b1; tick(); trigger = 1'b0;
        repeat (13) tick();
        check("t3_count", wcount, 12);
        for (int i = 0; i < 12; i++) begin
            check("t3_addr", wr_addr[i], i);
            check("t3_data", wr_data[i], ((t + 1 + i) * 4 + (i % 4)) & 255);
        end
        check("t3_done", done, 1'b1);
        check("t3_addr_hold", mem_w_addr, 16'd11);
        done_ack = 1'b1; tick(); done_ack = 1'b0;

        // 300 x 4 channels exceeds the 1024-word memory and is clamped.
        configure(0, 300, 0, 1, 0);
        check("t4_clamp", cfg_clamped, 1'b1);
        arm = 1'b1; tick(); arm = 1'b0;
        wcount = 0; t = ncyc;
        trigger = 1'b1; tick(); trigger = 1'b0;
        wait_done(1100);
        check("t4_done", done, 1'b1);
        check("t4_done_cyc", ncyc, t + 1026);
        check("t4_count", wcount, 1024);
        check("t4_last_addr", wr_addr[1023], 1023);
        check("t4_addr_hold", mem_w_addr, 16'd1023);
        done_ack = 1'b1; tick(); done_ack = 1'b0;

        // Event handling: idle trigger, arm+trigger together, retrigger during capture.
        configure(0, 8, 0, 0, 0);
        check("t5_clamp_clr", cfg_clamped, 1'b0);
        wcount = 0;
        trigger = 1'b1; tick(); trigger = 1'b0;
        repeat (4) tick();
        check("t5_idle_trig_wr", wcount, 0);
        check("t5_idle_trig_busy", busy, 1'b0);
        arm = 1'b1; trigger = 1'b1; tick(); arm = 1'b0; trigger = 1'b0;
        repeat (3) tick();
        check("t5_armtrig_busy", busy, 1'b1);
        check("t5_armtrig_wr", wcount, 0);
        cfg_len = 16'd2; cfg_wr = 1'b1; tick(); cfg_wr = 1'b0;
        t = ncyc;
        trigger = 1'b1; tick(); trigger = 1'b0;
        tick(); tick();
        trigger = 1'b1; tick(); trigger = 1'b0;
        check("t5_retrig_set", retrig, 1'b1);
        wait_done(20);
        check("t5_done", done, 1'b1);
        check("t5_done_cyc", ncyc, t + 10);
        check("t5_count", wcount, 8);
        done_ack = 1'b1; tick(); done_ack = 1'b0;
        check("t5_retrig_sticky", retrig, 1'b1);
        arm = 1'b1; tick(); arm = 1'b0;
        check("t5_retrig_clr", retrig, 1'b0);

        // Reset in the middle of a capture, then a fresh capture from address 0.
        wcount = 0;
        trigger = 1'b1; tick(); trigger = 1'b0;
        repeat (3) tick();
        check("t6_third_wr", wcount, 3);
        check("t6_third_addr", mem_w_addr, 16'd2);
        rst = 1'b1; tick(); rst = 1'b0;
        check("t6_rst_wen", mem_w_en, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        repeat (12) tick();
        check("t6_rst_nodone", done, 1'b0);
        check("t6_rst_count", wcount, 3);
        configure(0, 8, 0, 0, 0);
        arm = 1'b1; tick(); arm = 1'b0;
        wcount = 0; t = ncyc;
        trigger = 1'b1; tick(); trigger = 1'b0;
        wait_done(20);
        check("t6_done", done, 1'b1);
        check("t6_count", wcount, 8);
        check("t6_first_addr", wr_addr[0], 0);
        check("t6_first_cyc", wr_cyc[0], t + 2);
        check("t6_first_data", wr_data[0], ((t + 1) * 4) & 255);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
